exec_mem_stage: RTL and testbench

- Execute stage plus Execute/Memory pipeline register.
- Consumes the E-stage control and data produced by the Decode/Execute register.
- Applies operand forwarding, runs the ALU, resolves branch/jump (PCSrcE, PCTargetE) back to fetch, and registers results into the M stage.
- Registered outputs feed the data memory and the M/W register.

---
 rtl/exec_mem_stage.sv | 88 ++++++++
 tb/tb_exec_mem_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_mem_stage.sv
// exec_mem_stage: execute stage (forwarding, ALU, branch resolve) plus the E/M pipeline register
module exec_mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int CONTROL_WIDTH  = 3,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      RegWriteE,
  input  logic                      MemWriteE,
  input  logic                      JumpE,
  input  logic                      BranchE,
  input  logic                      ALUSrcE,
  input  logic [1:0]                ResultSrcE,
  input  logic [CONTROL_WIDTH-1:0]  ALUControlE,
  input  logic [DATA_WIDTH-1:0]     RD1E,
  input  logic [DATA_WIDTH-1:0]     RD2E,
  input  logic [DATA_WIDTH-1:0]     ImmExtE,
  input  logic [DATA_WIDTH-1:0]     PCE,
  input  logic [DATA_WIDTH-1:0]     PCPlus4E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [1:0]                ForwardAE,
  input  logic [1:0]                ForwardBE,
  input  logic [DATA_WIDTH-1:0]     ResultW,
  output logic                      PCSrcE,
  output logic [DATA_WIDTH-1:0]     PCTargetE,
  output logic                      RegWriteM,
  output logic                      MemWriteM,
  output logic [1:0]                ResultSrcM,
  output logic [DATA_WIDTH-1:0]     ALUResultM,
  output logic [DATA_WIDTH-1:0]     WriteDataM,
  output logic [DATA_WIDTH-1:0]     PCPlus4M,
  output logic [REG_ADDR_WIDTH-1:0] RdM
);
  logic [DATA_WIDTH-1:0] w_src_a;
  logic [DATA_WIDTH-1:0] w_write_data;
  logic [DATA_WIDTH-1:0] w_src_b;
  logic [DATA_WIDTH-1:0] w_alu_result;
  logic                  w_lt;
  // Forwarding muxes: 10 takes the M-stage ALU result, 01 the writeback result, else the register file
  always_comb begin
    w_src_a      = ForwardAE == 2'b10 ? ALUResultM : ForwardAE == 2'b01 ? ResultW : RD1E;
    w_write_data = ForwardBE == 2'b10 ? ALUResultM : ForwardBE == 2'b01 ? ResultW : RD2E;
    w_src_b      = ALUSrcE ? ImmExtE : w_write_data;
    w_lt         = $signed(w_src_a) < $signed(w_src_b);
  end
  // ALU; add/sub wrap, shifts use only the low five bits of SrcB
  always_comb begin
    w_alu_result = '0;
    case (ALUControlE)
      3'd0:    w_alu_result = w_src_a + w_src_b;
      3'd1:    w_alu_result = w_src_a - w_src_b;
      3'd2:    w_alu_result = w_src_a & w_src_b;
      3'd3:    w_alu_result = w_src_a | w_src_b;
      3'd4:    w_alu_result = w_src_a ^ w_src_b;
      3'd5:    w_alu_result = {{(DATA_WIDTH-1){1'b0}}, w_lt};
      3'd6:    w_alu_result = w_src_a << w_src_b[4:0];
      default: w_alu_result = w_src_a >> w_src_b[4:0];
    endcase
  end
  // Branch resolution goes straight back to fetch in the same cycle
  always_comb begin
    PCSrcE    = JumpE | (BranchE & (w_alu_result == '0));
    PCTargetE = PCE + ImmExtE;
  end
  // E/M register: async reset, then flush (bubble) beats stall (hold), else load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || flush) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
    end else if (!stall) begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      ALUResultM <= w_alu_result;
      WriteDataM <= w_write_data;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE;
    end
  end
endmodule

// File: tb/tb_exec_mem_stage.sv
// tb_exec_mem_stage: directed literal checks plus randomized stimulus against a behavioural model
module tb_exec_mem_stage;
  logic        clk = 0, reset = 1, stall = 0, flush = 0;
  logic        RegWriteE = 0, MemWriteE = 0, JumpE = 0, BranchE = 0, ALUSrcE = 0;
  logic [1:0]  ResultSrcE = 0, ForwardAE = 0, ForwardBE = 0;
  logic [2:0]  ALUControlE = 0;
  logic [31:0] RD1E = 0, RD2E = 0, ImmExtE = 0, PCE = 0, PCPlus4E = 0, ResultW = 0;
  logic [4:0]  RdE = 0;
  logic        PCSrcE, RegWriteM, MemWriteM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;
  int errors = 0, checks = 0;
  bit cmp_en = 0;
  logic        m_rw, m_mw;
  logic [1:0]  m_rs;
  logic [31:0] m_alu, m_wd, m_pc4;
  logic [4:0]  m_rd;

  exec_mem_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M), .RdM(RdM)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd);
    if (sel == 2'b10) return m_alu;
    if (sel == 2'b01) return ResultW;
    return rd;
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (sa < sb) ? 32'd1 : 32'd0;
      6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  function automatic logic [31:0] e_result();
    return alu(ALUControlE, fwd(ForwardAE, RD1E), ALUSrcE ? ImmExtE : fwd(ForwardBE, RD2E));
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Reference M stage: reset clears, flush bubbles, stall holds, otherwise capture E results
  always @(posedge clk or negedge reset) begin
    if (!reset || flush) begin
      m_rw <= 0; m_mw <= 0; m_rs <= 0; m_alu <= 0; m_wd <= 0; m_pc4 <= 0; m_rd <= 0;
    end else if (!stall) begin
      m_rw <= RegWriteE; m_mw <= MemWriteE; m_rs <= ResultSrcE; m_alu <= e_result();
      m_wd <= fwd(ForwardBE, RD2E); m_pc4 <= PCPlus4E; m_rd <= RdE;
    end
  end

  // Compare every falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("PCSrcE", 32'(PCSrcE), 32'(JumpE || (BranchE && e_result() == 0)));
      chk("PCTargetE", PCTargetE, PCE + ImmExtE);
      chk("RegWriteM", 32'(RegWriteM), 32'(m_rw));
      chk("MemWriteM", 32'(MemWriteM), 32'(m_mw));
      chk("ResultSrcM", 32'(ResultSrcM), 32'(m_rs));
      chk("ALUResultM", ALUResultM, m_alu);
      chk("WriteDataM", WriteDataM, m_wd);
      chk("PCPlus4M", PCPlus4M, m_pc4);
      chk("RdM", 32'(RdM), 32'(m_rd));
    end
  end

  task automatic go();
    @(negedge clk);
    #1;
  endtask

  task automatic set_e(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic rw, input logic mw);
    ALUControlE = op; RD1E = a; RD2E = b; RdE = rd; RegWriteE = rw; MemWriteE = mw;
    ALUSrcE = 0; ForwardAE = 0; ForwardBE = 0; BranchE = 0; JumpE = 0;
  endtask

  initial begin
    #2 reset = 0;
    go();
    reset = 1;
    cmp_en = 1;
    // 1: async reset clears in-flight state immediately
    set_e(0, 32'h1234, 0, 3, 1, 0);
    go();
    chk("preload", ALUResultM, 32'h1234);
    #2 reset = 0;
    #1;
    chk("async_rst_alu", ALUResultM, 0);
    chk("async_rst_rw", 32'(RegWriteM), 0);
    chk("async_rst_rd", 32'(RdM), 0);
    go();
    reset = 1;
    set_e(0, 5, 7, 1, 1, 0);
    go();
    chk("add_5_7", ALUResultM, 12);
    chk("add_rw", 32'(RegWriteM), 1);
    // 2: op sweep
    set_e(1, 3, 5, 2, 1, 0);
    go();
    chk("sub", ALUResultM, 32'hFFFFFFFE);
    set_e(5, 32'hFFFFFFFF, 1, 2, 1, 0);
    go();
    chk("slt", ALUResultM, 1);
    set_e(6, 1, 31, 2, 1, 0);
    go();
    chk("sll", ALUResultM, 32'h80000000);
    set_e(7, 32'h80000000, 31, 2, 1, 0);
    go();
    chk("srl", ALUResultM, 1);
    // 3: forwarding
    set_e(0, 100, 0, 4, 1, 0);
    go();
    set_e(0, 0, 0, 4, 1, 0);
    ForwardAE = 2'b10; ImmExtE = 1; ALUSrcE = 1;
    go();
    chk("fwd_a_mem", ALUResultM, 101);
    set_e(0, 0, 0, 0, 0, 1);
    ForwardBE = 2'b01; ResultW = 32'hAA;
    go();
    chk("fwd_b_wb", WriteDataM, 32'hAA);
    chk("fwd_b_mw", 32'(MemWriteM), 1);
    // 4: branch resolution in E
    set_e(1, 9, 9, 0, 0, 0);
    BranchE = 1; PCE = 32'h40; ImmExtE = 32'h10;
    #1;
    chk("beq_taken", 32'(PCSrcE), 1);
    chk("beq_target", PCTargetE, 32'h50);
    RD2E = 8;
    #1;
    chk("beq_not_taken", 32'(PCSrcE), 0);
    JumpE = 1;
    #1;
    chk("jump", 32'(PCSrcE), 1);
    // 5: stall holds, flush beats stall
    set_e(0, 20, 22, 5, 1, 0);
    go();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_e(3'($urandom), $urandom, $urandom, 5'($urandom), 0, 1);
      go();
      chk("stall_alu", ALUResultM, 42);
      chk("stall_rd", 32'(RdM), 5);
    end
    flush = 1;
    go();
    chk("flush_rw", 32'(RegWriteM), 0);
    chk("flush_mw", 32'(MemWriteM), 0);
    chk("flush_rd", 32'(RdM), 0);
    stall = 0; flush = 0;
    // 6: back-to-back dependent adds
    set_e(0, 2, 3, 1, 1, 0);
    go();
    chk("dep1", ALUResultM, 5);
    set_e(0, 0, 0, 2, 1, 0);
    ForwardAE = 2'b10; ForwardBE = 2'b10;
    go();
    chk("dep2", ALUResultM, 10);
    // Randomized phase checked by the model
    for (int i = 0; i < 500; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      set_e(3'($urandom), a, b, 5'($urandom), 1'($urandom), 1'($urandom));
      ALUSrcE = 1'($urandom); ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
      BranchE = 1'($urandom); JumpE = ($urandom_range(0, 7) == 0);
      ResultSrcE = 2'($urandom); ImmExtE = $urandom; PCE = $urandom; PCPlus4E = $urandom;
      ResultW = $urandom;
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 49) != 0);
      go();
    end
    reset = 1;
    go();
    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
